uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Receive-side command stage of the FPGA_modulo link. It sits directly downstream of `uart_rx` and consumes each received byte as a Hamming(7,4)-protected command. It corrects single-bit errors, executes ON/OFF/TOGGLE on the module's output-enable, and returns an ACK/NAK byte through `uart_tx`. A watchdog drops the enable if the master stops talking.

## Interface
- `TIMEOUT_CYCLES`, default 48_000_000: cycles without a valid command before `out_en` is forced off (1 s at 48 MHz).
- `ACK_BYTE`, default 8'h3C: reply to an executed command.
- `NAK_BYTE`, default 8'hC3: reply to an undecodable or unknown command.
- `clk` in 1: system clock (48 MHz HFOSC).
- `reset` in 1: synchronous, active-high reset.
- `data_received` in 8: byte from `uart_rx`.
- `rx_done` in 1: one-cycle strobe from `uart_rx`; `data_received` is valid in that cycle.
- `parity_error` in 1: qualifies `rx_done`; when high, the byte is discarded.
- `tx_busy` in 1: from `uart_tx`.
- `data_to_tx` out 8: reply byte to `uart_tx`.
- `start_tx` out 1: one-cycle request to `uart_tx`.
- `out_en` out 1: SPWM output enable.
- `cmd_valid` out 1: one-cycle pulse when a command executes.
- `corrected` out 1: one-cycle pulse with `cmd_valid` if a bit was corrected.
- `timeout` out 1: one-cycle pulse when the watchdog clears `out_en`.
- `err_count` out 8: saturating count of rejected bytes, parity errors and overruns.

## Operation
- Frame format:
  - bit7 is the marker and must be 1.
  - bits6:0 hold the Hamming codeword, with byte bit i = codeword position i+1.
  - Codeword positions: p1=b0, p2=b1, d0=b2, p4=b3, d1=b4, d2=b5, d3=b6.
  - Parity bits: p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
- Syndrome:
  - s1 = b0^b2^b4^b6, s2 = b1^b2^b5^b6, s4 = b3^b4^b5^b6, with s = {s4,s2,s1}.
  - If s != 0, flip byte bit s-1 and set the corrected flag.
- Command nibble is {d3,d2,d1,d0}:
  - 4'h6 ON: `out_en` <= 1.
  - 4'hD OFF: `out_en` <= 0.
  - 4'h9 TOGGLE: `out_en` <= ~`out_en`.
  - Any other nibble: no change, reply `NAK_BYTE`, increment `err_count`.
- Marker = 0: reject. Reply NAK, increment `err_count`, `out_en` unchanged.
- `rx_done` with `parity_error`=1: drop the byte, increment `err_count`, send no reply.
- FSM states: IDLE, DECODE, EXEC, TX_WAIT_HI, TX_WAIT_LO.
  - IDLE: on a valid `rx_done` (or a pending hold byte), latch the byte → DECODE.
  - DECODE: compute the syndrome, register the corrected nibble → EXEC.
  - EXEC: apply the command, pulse `cmd_valid` (valid commands only), load `data_to_tx`, pulse `start_tx` → TX_WAIT_HI.
  - TX_WAIT_HI: wait for `tx_busy`=1 → TX_WAIT_LO.
  - TX_WAIT_LO: wait for `tx_busy`=0 → IDLE.
- Single-entry hold register:
  - A good byte arriving outside IDLE is stored in the hold register and processed on the next IDLE.
  - A second arrival while the hold register is full is dropped and increments `err_count`; the held byte is kept.
- Watchdog:
  - Counter clears on every `cmd_valid` and whenever `out_en`=0.
  - Otherwise it increments while `out_en`=1.
  - When it reaches `TIMEOUT_CYCLES`-1: `out_en` <= 0, pulse `timeout`, counter clears.
  - A command executing in the same cycle as expiry wins; `timeout` does not pulse.
- `err_count` saturates at 8'hFF.

## Timing
- Reset values: `out_en`=0, `start_tx`=0, `data_to_tx`=8'h00, `cmd_valid`=0, `corrected`=0, `timeout`=0, `err_count`=0, FSM=IDLE, hold register empty, watchdog=0.
- Reset asserted mid-reply: `start_tx` drops at the next edge; any transfer already started in `uart_tx` is not tracked further.
- Latency, with `rx_done` high at edge N:
  - Byte latched at N.
  - DECODE at N+1.
  - `out_en`, `cmd_valid`, `corrected`, `data_to_tx` and `start_tx` all change at edge N+2.
  - `start_tx` deasserts at N+3.
- `start_tx` is high for exactly 1 cycle per reply.
- `data_to_tx` is held stable until the FSM returns to IDLE.
- Back-to-back commands: a held byte enters DECODE on the cycle after the FSM reaches IDLE.

## Test plan
- Reset, then `rx_done` with 8'hB3 → `out_en`=1 at N+2, `cmd_valid` pulses, `corrected`=0, `data_to_tx`=8'h3C, `start_tx` pulses once.
- 8'hA3 (8'hB3 with bit4 flipped) → syndrome 5, `corrected` pulses, `out_en`=1, ACK sent. Then 8'hE6 → `out_en`=0. Then 8'hCC twice → `out_en` goes 1, then 0.
- 8'h33 (marker clear) → NAK 8'hC3 sent, `err_count`=1, `out_en` unchanged. `rx_done` with `parity_error`=1 → no `start_tx`, `err_count`=2.
- Three bytes 8'hB3, 8'hE6, 8'hCC arrive during one reply, with `tx_busy` held high → first two processed in order, third dropped, `err_count`+1, final `out_en`=0.
- `TIMEOUT_CYCLES`=100, send 8'hB3, then stay idle → `timeout` pulses and `out_en`=0 exactly 100 cycles after `cmd_valid`. Sending 8'hB3 every 50 cycles → `out_en` stays 1.
- 300 parity-error bytes → `err_count` holds at 8'hFF. Reset asserted in TX_WAIT_LO → all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder_if
//  Brief    : Byte-level link between uart_rx / uart_tx and the command
//             decoder, plus the decoder's status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if;
    // Receive side (from uart_rx)
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    // Transmit side (to / from uart_tx)
    logic       tx_busy;
    logic [7:0] data_to_tx;
    logic       start_tx;
    // Status / control outputs
    logic       out_en;
    logic       cmd_valid;
    logic       corrected;
    logic       timeout;
    logic [7:0] err_count;

    // Decoder side
    modport slave (
        input  data_received,
        input  rx_done,
        input  parity_error,
        input  tx_busy,
        output data_to_tx,
        output start_tx,
        output out_en,
        output cmd_valid,
        output corrected,
        output timeout,
        output err_count
    );

    // Environment side (UART pair and consumers)
    modport master (
        output data_received,
        output rx_done,
        output parity_error,
        output tx_busy,
        input  data_to_tx,
        input  start_tx,
        input  out_en,
        input  cmd_valid,
        input  corrected,
        input  timeout,
        input  err_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder
//  Brief    : Hamming(7,4)-protected command decoder. Corrects single-bit
//             errors, drives the SPWM output enable (ON/OFF/TOGGLE), replies
//             ACK/NAK through uart_tx and drops the enable on link silence.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 48_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h3C,
    parameter logic [7:0]  NAK_BYTE       = 8'hC3
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_decoder_if.slave bus
);

    // Watchdog width: just enough to hold TIMEOUT_CYCLES-1
    localparam int unsigned     c_wd_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] c_cmd_on  = 4'h6;
    localparam logic [3:0] c_cmd_off = 4'hD;
    localparam logic [3:0] c_cmd_tgl = 4'h9;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DECODE     = 3'd1,
        EXEC       = 3'd2,
        TX_WAIT_HI = 3'd3,
        TX_WAIT_LO = 3'd4
    } state_t;

    state_t            r_state;
    logic [7:0]        r_byte;
    logic [7:0]        r_hold;
    logic              r_hold_full;
    logic [3:0]        r_nibble;
    logic              r_marker;
    logic              r_fixed;
    logic [c_wd_w-1:0] r_wd_cnt;

    logic [7:0]        r_data_to_tx;
    logic              r_start_tx;
    logic              r_out_en;
    logic              r_cmd_valid;
    logic              r_corrected;
    logic              r_timeout;
    logic [7:0]        r_err_count;

    logic [2:0]        w_syn;
    logic [6:0]        w_code;
    logic [3:0]        w_nibble;
    logic              w_cmd_ok;
    logic              w_next_en;
    logic              w_exec_ok;
    logic              w_exec_nak;
    logic              w_rx_good;
    logic              w_rx_bad;
    logic              w_hold_take;
    logic              w_rx_direct;
    logic              w_rx_to_hold;
    logic              w_rx_drop;
    logic [1:0]        w_err_inc;
    logic [8:0]        w_err_sum;

    // Syndrome and single-bit correction of the latched codeword
    always_comb begin
        w_syn[0] = r_byte[0] ^ r_byte[2] ^ r_byte[4] ^ r_byte[6];
        w_syn[1] = r_byte[1] ^ r_byte[2] ^ r_byte[5] ^ r_byte[6];
        w_syn[2] = r_byte[3] ^ r_byte[4] ^ r_byte[5] ^ r_byte[6];
        w_code   = r_byte[6:0];
        if (w_syn != 3'd0) begin
            w_code[w_syn - 3'd1] = ~w_code[w_syn - 3'd1];
        end
        w_nibble = {w_code[6], w_code[5], w_code[4], w_code[2]};
    end

    // Command classification and the enable value it produces
    always_comb begin
        w_cmd_ok  = r_marker && ((r_nibble == c_cmd_on) ||
                                 (r_nibble == c_cmd_off) ||
                                 (r_nibble == c_cmd_tgl));
        w_next_en = ~r_out_en;
        if (r_nibble == c_cmd_on) begin
            w_next_en = 1'b1;
        end else if (r_nibble == c_cmd_off) begin
            w_next_en = 1'b0;
        end
    end

    assign w_exec_ok  = (r_state == EXEC) && w_cmd_ok;
    assign w_exec_nak = (r_state == EXEC) && !w_cmd_ok;

    // Byte routing: IDLE drains the hold register first; a fresh byte can
    // refill the hold slot in the same cycle the old entry is taken.
    assign w_rx_good    = bus.rx_done && !bus.parity_error;
    assign w_rx_bad     = bus.rx_done && bus.parity_error;
    assign w_hold_take  = (r_state == IDLE) && r_hold_full;
    assign w_rx_direct  = w_rx_good && (r_state == IDLE) && !r_hold_full;
    assign w_rx_to_hold = w_rx_good && !w_rx_direct && (!r_hold_full || w_hold_take);
    assign w_rx_drop    = w_rx_good && !w_rx_direct && !w_rx_to_hold;

    // Parity errors and overruns are exclusive, a NAK may coincide with either
    assign w_err_inc = {1'b0, w_rx_bad | w_rx_drop} + {1'b0, w_exec_nak};
    assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_inc};

    // Main sequencer: byte capture, decode, execute, reply handshake, watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_byte       <= 8'h00;
            r_hold       <= 8'h00;
            r_hold_full  <= 1'b0;
            r_nibble     <= 4'h0;
            r_marker     <= 1'b0;
            r_fixed      <= 1'b0;
            r_wd_cnt     <= '0;
            r_data_to_tx <= 8'h00;
            r_start_tx   <= 1'b0;
            r_out_en     <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_corrected  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_start_tx  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_corrected <= 1'b0;
            r_timeout   <= 1'b0;

            if (w_rx_to_hold) begin
                r_hold      <= bus.data_received;
                r_hold_full <= 1'b1;
            end else if (w_hold_take) begin
                r_hold_full <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_hold_full) begin
                        r_byte  <= r_hold;
                        r_state <= DECODE;
                    end else if (w_rx_good) begin
                        r_byte  <= bus.data_received;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_nibble <= w_nibble;
                    r_marker <= r_byte[7];
                    r_fixed  <= (w_syn != 3'd0);
                    r_state  <= EXEC;
                end
                EXEC: begin
                    r_start_tx <= 1'b1;
                    r_state    <= TX_WAIT_HI;
                    if (w_cmd_ok) begin
                        r_data_to_tx <= ACK_BYTE;
                        r_cmd_valid  <= 1'b1;
                        r_corrected  <= r_fixed;
                    end else begin
                        r_data_to_tx <= NAK_BYTE;
                    end
                end
                TX_WAIT_HI: begin
                    if (bus.tx_busy) begin
                        r_state <= TX_WAIT_LO;
                    end
                end
                TX_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // An executing command takes priority over watchdog expiry
            if (w_exec_ok) begin
                r_out_en <= w_next_en;
                r_wd_cnt <= '0;
            end else if (!r_out_en) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt == c_wd_last) begin
                r_out_en  <= 1'b0;
                r_timeout <= 1'b1;
                r_wd_cnt  <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    // Saturating count of parity errors, overruns and rejected commands
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= 8'h00;
        end else if (w_err_sum[8]) begin
            r_err_count <= 8'hFF;
        end else begin
            r_err_count <= w_err_sum[7:0];
        end
    end

    assign bus.data_to_tx = r_data_to_tx;
    assign bus.start_tx   = r_start_tx;
    assign bus.out_en     = r_out_en;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.corrected  = r_corrected;
    assign bus.timeout    = r_timeout;
    assign bus.err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_decoder
//  Brief    : Scoreboard bench for uart_cmd_decoder with a simple uart_tx
//             busy model and directed command sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

    localparam int unsigned c_to  = 100;
    localparam logic [7:0]  c_ack = 8'h3C;
    localparam logic [7:0]  c_nak = 8'hC3;

    typedef struct packed {
        logic [7:0] data;
        logic       oe;
        logic       cv;
        logic       corr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_busy = 1'b0;
    logic expect_to = 1'b0;
    logic prev_start = 1'b0;
    int   busy_cnt = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES(c_to),
        .ACK_BYTE      (c_ack),
        .NAK_BYTE      (c_nak)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    // uart_tx stand-in: busy for 4 cycles after each start request
    always @(posedge clk) begin
        if (bus.start_tx) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = hold_busy | (busy_cnt != 0);

    // Monitor: every reply is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (bus.start_tx) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL reply_unexpected: got data=%h out_en=%b, expected no reply",
                         bus.data_to_tx, bus.out_en);
            end else begin
                e = sb.pop_front();
                if ({bus.data_to_tx, bus.out_en, bus.cmd_valid, bus.corrected, prev_start} !==
                    {e.data, e.oe, e.cv, e.corr, 1'b0}) begin
                    bad++;
                    $display("FAIL reply: got data=%h oe=%b cv=%b corr=%b prev_start=%b, want data=%h oe=%b cv=%b corr=%b prev_start=0",
                             bus.data_to_tx, bus.out_en, bus.cmd_valid, bus.corrected, prev_start,
                             e.data, e.oe, e.cv, e.corr);
                end
            end
        end
        if (bus.timeout) begin
            total++;
            if (!expect_to) begin
                bad++;
                $display("FAIL timeout_unexpected: got timeout=1, want 0");
            end
        end
        prev_start = bus.start_tx;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic oe, input logic cv, input logic corr);
        exp_t x;
        x.data = d; x.oe = oe; x.cv = cv; x.corr = corr;
        sb.push_back(x);
    endtask

    // Called at a negedge; rx_done is sampled at the following posedge
    task automatic send(input logic [7:0] b, input logic perr);
        bus.data_received = b;
        bus.rx_done       = 1'b1;
        bus.parity_error  = perr;
        @(negedge clk);
        bus.rx_done      = 1'b0;
        bus.parity_error = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        hold_busy = 1'b0;
        bus.rx_done = 1'b0;
        bus.parity_error = 1'b0;
        bus.data_received = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_limit: run exceeded time bound");
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        int k;
        bus.data_received = 8'h00;
        bus.rx_done       = 1'b0;
        bus.parity_error  = 1'b0;

        // Reset values and ON latency
        do_reset();
        check("rst_out_en",    bus.out_en,     0);
        check("rst_start_tx",  bus.start_tx,   0);
        check("rst_data_tx",   bus.data_to_tx, 0);
        check("rst_cmd_valid", bus.cmd_valid,  0);
        check("rst_corrected", bus.corrected,  0);
        check("rst_timeout",   bus.timeout,    0);
        check("rst_err",       bus.err_count,  0);

        push(c_ack, 1'b1, 1'b1, 1'b0);
        send(8'hB3, 1'b0);
        check("lat_n0_out_en", bus.out_en, 0);
        check("lat_n0_start",  bus.start_tx, 0);
        @(negedge clk);
        check("lat_n1_out_en", bus.out_en, 0);
        @(negedge clk);
        check("lat_n2_out_en", bus.out_en, 1);
        check("lat_n2_start",  bus.start_tx, 1);
        @(negedge clk);
        check("lat_n3_start",  bus.start_tx, 0);
        wait_cycles(12);

        // Correction, OFF, TOGGLE x2
        push(c_ack, 1'b1, 1'b1, 1'b1); send(8'hA3, 1'b0); wait_cycles(12);
        push(c_ack, 1'b0, 1'b1, 1'b0); send(8'hE6, 1'b0); wait_cycles(12);
        push(c_ack, 1'b1, 1'b1, 1'b0); send(8'hCC, 1'b0); wait_cycles(12);
        push(c_ack, 1'b0, 1'b1, 1'b0); send(8'hCC, 1'b0); wait_cycles(12);
        check("s2_err", bus.err_count, 0);

        // Rejections: marker clear, parity error, unknown nibble
        do_reset();
        push(c_nak, 1'b0, 1'b0, 1'b0); send(8'h33, 1'b0); wait_cycles(12);
        check("s3_err_marker", bus.err_count, 1);
        send(8'h33, 1'b1); wait_cycles(12);
        check("s3_err_parity", bus.err_count, 2);
        push(c_nak, 1'b0, 1'b0, 1'b0); send(8'h80, 1'b0); wait_cycles(12);
        check("s3_err_unknown", bus.err_count, 3);
        check("s3_out_en", bus.out_en, 0);

        // Three bytes during one reply: second held, third dropped
        do_reset();
        hold_busy = 1'b1;
        push(c_ack, 1'b1, 1'b1, 1'b0);
        push(c_ack, 1'b0, 1'b1, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hE6, 1'b0);
        send(8'hCC, 1'b0);
        wait_cycles(10);
        check("s4_err_overrun", bus.err_count, 1);
        check("s4_pending", sb.size(), 1);
        hold_busy = 1'b0;
        wait_cycles(30);
        check("s4_out_en", bus.out_en, 0);
        check("s4_drained", sb.size(), 0);

        // Watchdog expiry exactly TIMEOUT_CYCLES after cmd_valid
        do_reset();
        push(c_ack, 1'b1, 1'b1, 1'b0);
        send(8'hB3, 1'b0);
        k = 0;
        while (!bus.cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("s5_cmd_seen", bus.cmd_valid, 1);
        expect_to = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (bus.timeout) break;
        end
        check("s5_timeout_delay", k, c_to);
        check("s5_out_en_off", bus.out_en, 0);
        @(negedge clk);
        check("s5_timeout_width", bus.timeout, 0);
        expect_to = 1'b0;

        // Keep-alive every 50 cycles keeps the enable up
        repeat (6) begin
            push(c_ack, 1'b1, 1'b1, 1'b0);
            send(8'hB3, 1'b0);
            wait_cycles(49);
        end
        check("s5_keepalive_oe", bus.out_en, 1);

        // err_count saturation, then reset during TX_WAIT_LO
        do_reset();
        repeat (300) send(8'h55, 1'b1);
        wait_cycles(3);
        check("s6_err_sat", bus.err_count, 8'hFF);
        hold_busy = 1'b1;
        push(c_ack, 1'b1, 1'b1, 1'b0);
        send(8'hB3, 1'b0);
        wait_cycles(6);
        check("s6_pre_rst_oe", bus.out_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check("s6_rst_out_en", bus.out_en, 0);
        check("s6_rst_start",  bus.start_tx, 0);
        check("s6_rst_data",   bus.data_to_tx, 0);
        check("s6_rst_err",    bus.err_count, 0);
        check("s6_rst_cv",     bus.cmd_valid, 0);
        rst = 1'b0;
        hold_busy = 1'b0;
        wait_cycles(2);
        push(c_ack, 1'b1, 1'b1, 1'b0);
        send(8'hCC, 1'b0);
        wait_cycles(12);
        check("s6_after_rst_oe", bus.out_en, 1);
        check("end_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
